// File: rtl/kyber_pkg.sv
// Shared constants and modular helpers for the Kyber NTT butterfly datapath.
// Mode encoding is consumed by butterfly_pipe (GS support gated by BFLY_GS_MODE_EN).
package kyber_pkg;

  localparam int KYBER_W    = 16;
  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = 62209;

  localparam logic BFLY_CT = 1'b0;
  localparam logic BFLY_GS = 1'b1;

  // Operands must already lie in [0,q); a single conditional correction suffices.
  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[31:0];
  endfunction

  function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    logic [31:0] d;
    if (a >= b) d = a - b;
    else        d = a + q - b;
    return d;
  endfunction

endpackage

// File: rtl/mont_mul_pipe.sv
// Two-stage Montgomery multiplier: stage 1 forms a*b, stage 2 reduces to a*b*R^-1 mod Q.
// Both stages advance only when i_en is high.
module mont_mul_pipe
  import kyber_pkg::*;
#(
  parameter int W    = KYBER_W,
  parameter int Q    = KYBER_Q,
  parameter int QINV = KYBER_QINV
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_r
);

  localparam logic [W-1:0] LP_Q    = W'(Q);
  localparam logic [W-1:0] LP_QINV = W'(QINV);

  logic [2*W-1:0] r_t;
  logic [W-1:0]   r_r;

  logic [W-1:0] w_t_lo;
  logic [W-1:0] w_t_hi;
  logic [W-1:0] w_m;
  logic [W-1:0] w_mq_lo;
  logic [W-1:0] w_mq_hi;
  logic         w_borrow;
  logic [W:0]   w_diff;
  logic [W-1:0] w_red;

  assign {w_t_hi, w_t_lo}   = r_t;
  assign w_m                = w_t_lo * LP_QINV;
  assign {w_mq_hi, w_mq_lo} = (2*W)'(w_m) * (2*W)'(LP_Q);

  // (t - m*Q) / R computed on the high halves only; the low halves cancel
  // exactly, so the borrow term is kept for generality but is zero in practice.
  assign w_borrow = (w_t_lo < w_mq_lo);
  assign w_diff   = {1'b0, w_t_hi} - {1'b0, w_mq_hi} - {{W{1'b0}}, w_borrow};
  assign w_red    = w_diff[W] ? (w_diff[W-1:0] + LP_Q) : w_diff[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t <= '0;
      r_r <= '0;
    end else if (i_en) begin
      r_t <= (2*W)'(i_a) * (2*W)'(i_b);
      r_r <= w_red;
    end
  end

  assign o_r = r_r;

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage Kyber NTT butterfly (CT forward, optional GS inverse).
// Define BFLY_GS_MODE_EN to enable GS mode; otherwise mode is ignored and CT is used.
module butterfly_pipe
  import kyber_pkg::*;
#(
  parameter int W     = KYBER_W,
  parameter int Q     = KYBER_Q,
  parameter int QINV  = KYBER_QINV,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [W-1:0]     u,
  input  logic [W-1:0]     v,
  input  logic [W-1:0]     zeta,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_upper,
  output logic [W-1:0]     out_lower,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [31:0] LP_Q32 = 32'(Q);

  // Handshake: a set is taken on in_valid && in_ready and a result leaves on
  // out_valid && out_ready. The whole pipe advances together unless a result
  // is stuck in S4, so in_ready never depends on in_valid and bubbles persist.
  logic w_advance;

  logic             r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
  logic             r_s1_mode,  r_s2_mode,  r_s3_mode;
  logic [TAG_W-1:0] r_s1_tag,   r_s2_tag,   r_s3_tag,   r_s4_tag;
  logic [W-1:0]     r_s1_keep,  r_s2_keep,  r_s3_keep;
  logic [W-1:0]     r_s1_mul_a, r_s1_zeta;
  logic [W-1:0]     r_s4_upper, r_s4_lower;

  logic         w_mode_eff;
  logic [W-1:0] w_s1_keep;
  logic [W-1:0] w_s1_mul_a;
  logic [W-1:0] w_mont;
  logic [W-1:0] w_s4_upper;
  logic [W-1:0] w_s4_lower;

  assign w_advance = !(r_s4_valid && !out_ready);
  assign in_ready  = w_advance;

`ifdef BFLY_GS_MODE_EN
  assign w_mode_eff = mode;

  always_comb begin
    w_s1_keep  = u;
    w_s1_mul_a = v;
    if (mode == BFLY_GS) begin
      w_s1_keep  = W'(mod_add(32'(u), 32'(v), LP_Q32));
      w_s1_mul_a = W'(mod_sub(32'(u), 32'(v), LP_Q32));
    end
  end
`else
  // Mode is forced to CT; S1 is a plain register stage.
  assign w_mode_eff = mode & BFLY_CT;
  assign w_s1_keep  = u;
  assign w_s1_mul_a = v;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= BFLY_CT;
      r_s1_tag   <= '0;
      r_s1_keep  <= '0;
      r_s1_mul_a <= '0;
      r_s1_zeta  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mode  <= BFLY_CT;
      r_s2_tag   <= '0;
      r_s2_keep  <= '0;
      r_s3_valid <= 1'b0;
      r_s3_mode  <= BFLY_CT;
      r_s3_tag   <= '0;
      r_s3_keep  <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_mode  <= w_mode_eff;
      r_s1_tag   <= in_tag;
      r_s1_keep  <= w_s1_keep;
      r_s1_mul_a <= w_s1_mul_a;
      r_s1_zeta  <= zeta;
      r_s2_valid <= r_s1_valid;
      r_s2_mode  <= r_s1_mode;
      r_s2_tag   <= r_s1_tag;
      r_s2_keep  <= r_s1_keep;
      r_s3_valid <= r_s2_valid;
      r_s3_mode  <= r_s2_mode;
      r_s3_tag   <= r_s2_tag;
      r_s3_keep  <= r_s2_keep;
    end
  end

  mont_mul_pipe #(
    .W    (W),
    .Q    (Q),
    .QINV (QINV)
  ) u_mont (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_advance),
    .i_a   (r_s1_mul_a),
    .i_b   (r_s1_zeta),
    .o_r   (w_mont)
  );

  always_comb begin
    w_s4_upper = W'(mod_add(32'(r_s3_keep), 32'(w_mont), LP_Q32));
    w_s4_lower = W'(mod_sub(32'(r_s3_keep), 32'(w_mont), LP_Q32));
    if (r_s3_mode == BFLY_GS) begin
      w_s4_upper = r_s3_keep;
      w_s4_lower = w_mont;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s4_valid <= 1'b0;
      r_s4_tag   <= '0;
      r_s4_upper <= '0;
      r_s4_lower <= '0;
    end else if (w_advance) begin
      r_s4_valid <= r_s3_valid;
      r_s4_tag   <= r_s3_tag;
      r_s4_upper <= w_s4_upper;
      r_s4_lower <= w_s4_lower;
    end
  end

  assign out_valid = r_s4_valid;
  assign out_tag   = r_s4_tag;
  assign out_upper = r_s4_upper;
  assign out_lower = r_s4_lower;

endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 SHALL have parameter W, default 16: coefficient width; Montgomery R = 2^W.
REQ-002 SHALL have parameter Q, default 3329: modulus.
REQ-003 SHALL have parameter QINV, default 62209: Q^-1 mod 2^W.
REQ-004 SHALL have parameter TAG_W, default 8: sideband tag width.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port in_valid, input, 1: operand set valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts the operand set.
REQ-009 SHALL have port mode, input, 1: 0 = Cooley-Tukey (CT, forward); 1 = Gentleman-Sande (GS, inverse).
REQ-010 SHALL have ports u, v, input, W each: coefficients, unsigned, range [0,Q).
REQ-011 SHALL have port zeta, input, W: twiddle in Montgomery form, range [0,Q).
REQ-012 SHALL have port in_tag, input, TAG_W: opaque sideband.
REQ-013 SHALL have port out_valid, output, 1: result valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have ports out_upper, out_lower, output, W: results, range [0,Q).
REQ-016 SHALL have port out_tag, output, TAG_W: in_tag delayed with its operand set.

Function
REQ-017 SHALL compute in CT mode: upper = (u + mont(v,zeta)) mod Q; lower = (u - mont(v,zeta)) mod Q.
REQ-018 SHALL compute in GS mode: upper = (u + v) mod Q; lower = mont((u - v) mod Q, zeta).
REQ-019 SHALL define mont(a,b) = a*b*R^-1 mod Q as follows: t = a*b (2W bits); m = (t mod R)*QINV mod R; r = (t - m*Q)/R (exact, signed); add Q if r < 0.
REQ-020 SHALL use a 4-stage pipeline, latency 4 cycles in both modes:
- S1: GS pre add/sub; CT pass-through.
- S2: multiply.
- S3: reduce.
- S4: CT post add/sub; GS pass-through.
REQ-021 SHALL carry mode and tag through every stage, so mixed-mode streams are legal back-to-back.
REQ-022 SHALL accept a transfer on in_valid && in_ready and emit on out_valid && out_ready.
REQ-023 SHALL generate advance = !(S4 valid && !out_ready), and drive in_ready = advance.
REQ-024 SHALL freeze all stages when advance = 0; bubbles shall not be compressed under stall.
REQ-025 SHALL sustain throughput of one operand set per cycle while out_ready = 1.
REQ-026 SHALL never lose, duplicate or reorder data.
REQ-027 SHALL hold out_* and out_tag stable while out_valid && !out_ready.
REQ-028 SHALL produce defined results only for inputs in [0,Q); behaviour for other inputs is undefined.

Reset
REQ-029 SHALL, on rst_n low, clear every stage valid immediately and drive out_valid = 0, out_upper = 0, out_lower = 0, out_tag = 0.
REQ-030 SHALL drive in_ready = 1 during reset.
REQ-031 SHALL discard all in-flight data on reset mid-operation; the first result after release shall come from the first post-reset input.

Configuration
REQ-032 SHALL, with BFLY_GS_MODE_EN defined, support both modes as specified.
REQ-033 SHALL, without BFLY_GS_MODE_EN, ignore mode and treat it as CT.
REQ-034 SHALL, without BFLY_GS_MODE_EN, keep S1 and S4 present so latency remains 4 and the GS add/sub logic is removed.

Structure
REQ-035 SHALL place the default Q, QINV and W constants, the mode encoding (BFLY_CT/BFLY_GS) and the modular add/sub helper functions in package kyber_pkg.
REQ-036 SHALL place the S2+S3 Montgomery multiply/reduce in sub-module mont_mul_pipe: 2 stages, with an enable input.

Verification
REQ-037 SHALL cover: CT, u=100, v=1, zeta=2285 (R mod Q) -> upper=101, lower=99, out_valid exactly 4 cycles after accept.
REQ-038 SHALL cover: CT wrap, u=3328, v=1, zeta=2285 -> upper=0, lower=3327; u=0, v=0 -> 0, 0.
REQ-039 SHALL cover (BFLY_GS_MODE_EN): GS u=5, v=3, zeta=2285 -> 8, 2; GS u=3, v=5, zeta=2285 -> 8, 3327; alternate CT/GS every cycle with correct per-item results.
REQ-040 SHALL cover: in_valid held high with out_ready=0 for 8 cycles -> exactly 4 accepts, then in_ready=0 and outputs stable; on release, tags emerge in order with no gaps or duplicates.
REQ-041 SHALL cover: rst_n pulsed low with 3 items in flight -> out_valid=0 and outputs 0 within the same cycle; no stale item appears after release.
REQ-042 SHALL cover: 10k random CT/GS vectors with random out_ready -> matches the golden model (mod Q arithmetic) and in_tag order is preserved.
